// File: rtl/trinity_bcast_arb_if.sv
// Requester/broadcast bundle for trinity_bcast_arb.
// The arbiter connects through the slave modport; the requester side (or a bench) uses master.
interface trinity_bcast_arb_if #(
    parameter int unsigned N_REQ = 3
);
    logic [N_REQ-1:0]   req_valid;
    logic [2*N_REQ-1:0] req_group;
    logic [2*N_REQ-1:0] req_mode;
    logic [N_REQ-1:0]   req_exec;
    logic [N_REQ-1:0]   req_ack;
    logic [7:0]         bus_out;
    logic               busy;
    logic [1:0]         last_grant;

    modport master (
        output req_valid,
        output req_group,
        output req_mode,
        output req_exec,
        input  req_ack,
        input  bus_out,
        input  busy,
        input  last_grant
    );

    modport slave (
        input  req_valid,
        input  req_group,
        input  req_mode,
        input  req_exec,
        output req_ack,
        output bus_out,
        output busy,
        output last_grant
    );
endinterface

// File: rtl/trinity_bcast_arb.sv
// Round-robin arbiter that serialises requester commands onto an 8-bit broadcast bus.
// Each grant emits a cfg frame, optionally followed (after a settle gap) by an exec frame,
// then a one-cycle guard. Every output is a flop loaded from next-state values.
module trinity_bcast_arb #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned SETTLE_CYC = 2
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    trinity_bcast_arb_if.slave arb
);

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StWait,
        StExec,
        StGuard
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         grp_q, grp_d;
    logic [1:0]         mode_q, mode_d;
    logic               exec_q, exec_d;
    logic [1:0]         rr_start_q, rr_start_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [7:0]         bus_q, bus_d;
    logic               busy_q;

    logic               grant_found;
    logic [1:0]         grant_idx;
    logic [2:0]         cand;

    // Frame layout: {valid, 0, group_id, cfg, exec, mode_sel}
    function automatic logic [7:0] make_frame(input logic [1:0] g, input logic cfg,
                                              input logic ex, input logic [1:0] m);
        return {1'b1, 1'b0, g, cfg, ex, m};
    endfunction

    // Round-robin search: first valid requester at or after rr_start_q, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 3'd0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_start_q} + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end
            if (!grant_found && arb.req_valid[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    // Next-state, payload latch and next output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grp_d        = grp_q;
        mode_d       = mode_q;
        exec_d       = exec_q;
        rr_start_d   = rr_start_q;
        last_grant_d = last_grant_q;
        ack_d        = '0;
        bus_d        = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d          = StCfg;
                    grp_d            = arb.req_group[{grant_idx, 1'b0} +: 2];
                    mode_d           = arb.req_mode[{grant_idx, 1'b0} +: 2];
                    exec_d           = arb.req_exec[grant_idx];
                    ack_d[grant_idx] = 1'b1;
                    last_grant_d     = grant_idx;
                    rr_start_d       = (grant_idx == 2'(N_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
                    bus_d            = make_frame(grp_d, 1'b1, 1'b0, mode_d);
                end
            end
            StCfg: begin
                if (exec_q) begin
                    if (SETTLE_CYC > 0) begin
                        state_d = StWait;
                        // Counts down to zero, so the last WAIT cycle sees cnt_q == 0.
                        cnt_d   = 4'(SETTLE_CYC - 1);
                    end else begin
                        state_d = StExec;
                        bus_d   = make_frame(grp_q, 1'b0, 1'b1, mode_q);
                    end
                end else begin
                    state_d = StGuard;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StExec;
                    bus_d   = make_frame(grp_q, 1'b0, 1'b1, mode_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StExec: begin
                state_d = StGuard;
            end
            StGuard: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, payload and registered outputs; reset aborts any transaction at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            grp_q        <= 2'd0;
            mode_q       <= 2'd0;
            exec_q       <= 1'b0;
            rr_start_q   <= 2'd0;
            last_grant_q <= 2'd0;
            ack_q        <= '0;
            bus_q        <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grp_q        <= grp_d;
            mode_q       <= mode_d;
            exec_q       <= exec_d;
            rr_start_q   <= rr_start_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            bus_q        <= bus_d;
            busy_q       <= (state_d != StIdle);
        end
    end

    assign arb.req_ack    = ack_q;
    assign arb.bus_out    = bus_q;
    assign arb.busy       = busy_q;
    assign arb.last_grant = last_grant_q;

    // Structural invariants of the outputs.
    ack_onehot0_a : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        $onehot0(ack_q));
    bus_bit6_zero_a : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        bus_q[6] == 1'b0);

endmodule

// File: tb/tb_trinity_bcast_arb.sv
// Directed bench for trinity_bcast_arb: one SETTLE_CYC=2 instance and one SETTLE_CYC=0 instance.
module tb_trinity_bcast_arb;

    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   failures;

    trinity_bcast_arb_if #(.N_REQ(3)) arb_a ();
    trinity_bcast_arb_if #(.N_REQ(3)) arb_b ();

    trinity_bcast_arb #(.N_REQ(3), .SETTLE_CYC(2)) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .arb       (arb_a.slave)
    );

    trinity_bcast_arb #(.N_REQ(3), .SETTLE_CYC(0)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .arb       (arb_b.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (arb_a.bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h want=00", arb_a.bus_out); end
        checks++; if (arb_a.req_ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b want=000", arb_a.req_ack); end
        checks++; if (arb_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", arb_a.busy); end
        checks++; if (arb_a.last_grant !== 2'd0) begin failures++; $display("FAIL reset_last_grant got=%0d want=0", arb_a.last_grant); end
        checks++; if (arb_b.bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus_b got=%h want=00", arb_b.bus_out); end
        sys_rst_n = 1'b1;
        tick();
        checks++; if (arb_a.busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%b want=0", arb_a.busy); end
    endtask

    task automatic test_cfg_only();
        arb_a.req_group = 6'b00_00_10;
        arb_a.req_mode  = 6'b00_00_11;
        arb_a.req_exec  = 3'b000;
        arb_a.req_valid = 3'b001;
        tick();
        checks++; if (arb_a.bus_out !== 8'hAB) begin failures++; $display("FAIL cfg_only_frame got=%h want=ab", arb_a.bus_out); end
        checks++; if (arb_a.req_ack !== 3'b001) begin failures++; $display("FAIL cfg_only_ack got=%b want=001", arb_a.req_ack); end
        checks++; if (arb_a.busy !== 1'b1) begin failures++; $display("FAIL cfg_only_busy_cfg got=%b want=1", arb_a.busy); end
        arb_a.req_valid = 3'b000;
        tick();
        checks++; if (arb_a.bus_out !== 8'h00) begin failures++; $display("FAIL cfg_only_guard got=%h want=00", arb_a.bus_out); end
        checks++; if (arb_a.req_ack !== 3'b000) begin failures++; $display("FAIL cfg_only_ack_guard got=%b want=000", arb_a.req_ack); end
        checks++; if (arb_a.busy !== 1'b1) begin failures++; $display("FAIL cfg_only_busy_guard got=%b want=1", arb_a.busy); end
        tick();
        checks++; if (arb_a.busy !== 1'b0) begin failures++; $display("FAIL cfg_only_busy_idle got=%b want=0", arb_a.busy); end
        checks++; if (arb_a.last_grant !== 2'd0) begin failures++; $display("FAIL cfg_only_last_grant got=%0d want=0", arb_a.last_grant); end
    endtask

    task automatic test_cfg_exec();
        logic [7:0] exp_seq [4];
        int exec_cnt;
        exp_seq = '{8'h00, 8'h00, 8'h96, 8'h00};
        // Pointer now starts at 1; requester 0 is found after wrapping.
        arb_a.req_group = 6'b00_00_01;
        arb_a.req_mode  = 6'b00_00_10;
        arb_a.req_exec  = 3'b001;
        arb_a.req_valid = 3'b001;
        tick();
        checks++; if (arb_a.bus_out !== 8'h9A) begin failures++; $display("FAIL exec_cfg_frame got=%h want=9a", arb_a.bus_out); end
        checks++; if (arb_a.req_ack !== 3'b001) begin failures++; $display("FAIL exec_cfg_ack got=%b want=001", arb_a.req_ack); end
        exec_cnt = int'(arb_a.bus_out[2]);
        arb_a.req_valid = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            exec_cnt += int'(arb_a.bus_out[2]);
            checks++; if (arb_a.bus_out !== exp_seq[i]) begin failures++; $display("FAIL exec_seq[%0d] got=%h want=%h", i, arb_a.bus_out, exp_seq[i]); end
        end
        checks++; if (exec_cnt != 1) begin failures++; $display("FAIL exec_pulse_width got=%0d want=1", exec_cnt); end
        tick();
        checks++; if (arb_a.busy !== 1'b0) begin failures++; $display("FAIL exec_busy_idle got=%b want=0", arb_a.busy); end
    endtask

    task automatic test_round_robin();
        int g_seq [4];
        logic [7:0] exp_frame;
        logic [2:0] exp_ack;
        logic [1:0] g2;
        logic [1:0] m2;
        bit got;
        g_seq = '{0, 1, 2, 0};
        sys_rst_n = 1'b0;
        tick();
        // Requester i: group i, mode 3-i.
        arb_a.req_group = 6'b10_01_00;
        arb_a.req_mode  = 6'b01_10_11;
        arb_a.req_exec  = 3'b000;
        arb_a.req_valid = 3'b111;
        sys_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                tick();
                if (arb_a.req_ack !== 3'b000) got = 1'b1;
            end
            g2 = 2'(g_seq[k]);
            m2 = 2'(3 - g_seq[k]);
            exp_ack   = 3'b001 << g_seq[k];
            exp_frame = {2'b10, g2, 2'b10, m2};
            checks++; if (!got) begin failures++; $display("FAIL rr_timeout[%0d] got=no_ack want=ack", k); end
            checks++; if (arb_a.req_ack !== exp_ack) begin failures++; $display("FAIL rr_ack[%0d] got=%b want=%b", k, arb_a.req_ack, exp_ack); end
            checks++; if (arb_a.last_grant !== g2) begin failures++; $display("FAIL rr_last_grant[%0d] got=%0d want=%0d", k, arb_a.last_grant, g2); end
            checks++; if (arb_a.bus_out !== exp_frame) begin failures++; $display("FAIL rr_frame[%0d] got=%h want=%h", k, arb_a.bus_out, exp_frame); end
        end
        arb_a.req_valid = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_busy_request();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'h00, 8'h00, 8'hB5, 8'h00, 8'h00};
        // Requester 0: group 3, mode 1, exec. Pointer is at 1 so search wraps to 0.
        arb_a.req_group = 6'b00_00_11;
        arb_a.req_mode  = 6'b00_10_01;
        arb_a.req_exec  = 3'b001;
        arb_a.req_valid = 3'b001;
        tick();
        checks++; if (arb_a.req_ack !== 3'b001) begin failures++; $display("FAIL busy_req_ack0 got=%b want=001", arb_a.req_ack); end
        checks++; if (arb_a.bus_out !== 8'hB9) begin failures++; $display("FAIL busy_req_cfg got=%h want=b9", arb_a.bus_out); end
        // Requester 1 arrives mid-transaction; requester 0 payload inputs are scrambled.
        arb_a.req_group = 6'b00_00_00;
        arb_a.req_mode  = 6'b00_10_11;
        arb_a.req_exec  = 3'b000;
        arb_a.req_valid = 3'b010;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (arb_a.req_ack !== 3'b000) begin failures++; $display("FAIL busy_req_no_ack[%0d] got=%b want=000", i, arb_a.req_ack); end
            checks++; if (arb_a.bus_out !== exp_seq[i]) begin failures++; $display("FAIL busy_req_seq[%0d] got=%h want=%h", i, arb_a.bus_out, exp_seq[i]); end
        end
        tick();
        checks++; if (arb_a.req_ack !== 3'b010) begin failures++; $display("FAIL busy_req_ack1 got=%b want=010", arb_a.req_ack); end
        checks++; if (arb_a.bus_out !== 8'h8A) begin failures++; $display("FAIL busy_req_frame1 got=%h want=8a", arb_a.bus_out); end
        checks++; if (arb_a.last_grant !== 2'd1) begin failures++; $display("FAIL busy_req_last_grant got=%0d want=1", arb_a.last_grant); end
        arb_a.req_valid = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_wait();
        arb_a.req_group = 6'b00_00_10;
        arb_a.req_mode  = 6'b00_00_01;
        arb_a.req_exec  = 3'b001;
        arb_a.req_valid = 3'b001;
        tick();
        checks++; if (arb_a.req_ack !== 3'b001) begin failures++; $display("FAIL rst_wait_ack got=%b want=001", arb_a.req_ack); end
        arb_a.req_valid = 3'b000;
        tick();
        checks++; if (arb_a.busy !== 1'b1) begin failures++; $display("FAIL rst_wait_busy_pre got=%b want=1", arb_a.busy); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++; if (arb_a.busy !== 1'b0) begin failures++; $display("FAIL rst_wait_busy_async got=%b want=0", arb_a.busy); end
        checks++; if (arb_a.bus_out !== 8'h00) begin failures++; $display("FAIL rst_wait_bus_async got=%h want=00", arb_a.bus_out); end
        checks++; if (arb_a.last_grant !== 2'd0) begin failures++; $display("FAIL rst_wait_last_grant got=%0d want=0", arb_a.last_grant); end
        arb_a.req_exec  = 3'b000;
        arb_a.req_valid = 3'b010;
        repeat (3) tick();
        checks++; if (arb_a.bus_out !== 8'h00) begin failures++; $display("FAIL rst_wait_no_exec got=%h want=00", arb_a.bus_out); end
        sys_rst_n = 1'b1;
        tick();
        checks++; if (arb_a.req_ack !== 3'b010) begin failures++; $display("FAIL rst_release_ack got=%b want=010", arb_a.req_ack); end
        checks++; if (arb_a.last_grant !== 2'd1) begin failures++; $display("FAIL rst_release_last_grant got=%0d want=1", arb_a.last_grant); end
        arb_a.req_valid = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_settle_zero();
        arb_b.req_group = 6'b00_00_10;
        arb_b.req_mode  = 6'b00_00_00;
        arb_b.req_exec  = 3'b001;
        arb_b.req_valid = 3'b001;
        tick();
        checks++; if (arb_b.bus_out !== 8'hA8) begin failures++; $display("FAIL s0_cfg got=%h want=a8", arb_b.bus_out); end
        checks++; if (arb_b.req_ack !== 3'b001) begin failures++; $display("FAIL s0_ack got=%b want=001", arb_b.req_ack); end
        arb_b.req_valid = 3'b000;
        tick();
        checks++; if (arb_b.bus_out !== 8'hA4) begin failures++; $display("FAIL s0_exec got=%h want=a4", arb_b.bus_out); end
        tick();
        checks++; if (arb_b.bus_out !== 8'h00) begin failures++; $display("FAIL s0_guard got=%h want=00", arb_b.bus_out); end
        checks++; if (arb_b.busy !== 1'b1) begin failures++; $display("FAIL s0_guard_busy got=%b want=1", arb_b.busy); end
        tick();
        checks++; if (arb_b.busy !== 1'b0) begin failures++; $display("FAIL s0_idle_busy got=%b want=0", arb_b.busy); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sys_rst_n = 1'b0;
        arb_a.req_valid = '0;
        arb_a.req_group = '0;
        arb_a.req_mode  = '0;
        arb_a.req_exec  = '0;
        arb_b.req_valid = '0;
        arb_b.req_group = '0;
        arb_b.req_mode  = '0;
        arb_b.req_exec  = '0;
        test_reset();
        test_cfg_only();
        test_cfg_exec();
        test_round_robin();
        test_busy_request();
        test_reset_mid_wait();
        test_settle_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
